// File: rtl/dmem_lane_arbiter_pkg.sv
// Shared definitions for the data-memory lane arbiter: ALU memory-op codes,
// hardware-counter address, FSM state type and op-width decode.
package dmem_lane_arbiter_pkg;

  localparam logic [5:0] ALU_LB  = 6'h10;
  localparam logic [5:0] ALU_LH  = 6'h11;
  localparam logic [5:0] ALU_LW  = 6'h12;
  localparam logic [5:0] ALU_LBU = 6'h13;
  localparam logic [5:0] ALU_LHU = 6'h14;
  localparam logic [5:0] ALU_SB  = 6'h18;
  localparam logic [5:0] ALU_SH  = 6'h19;
  localparam logic [5:0] ALU_SW  = 6'h1a;

  localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'hffffff00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } op_size_t;

  // SZ_NONE marks an alucode that is not a memory op; such requests are ignored.
  function automatic op_size_t alu_size(input logic [5:0] code);
    case (code)
      ALU_LB, ALU_LBU, ALU_SB: return SZ_BYTE;
      ALU_LH, ALU_LHU, ALU_SH: return SZ_HALF;
      ALU_LW, ALU_SW:          return SZ_WORD;
      default:                 return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_arbiter_if.sv
// Bundle between the two issue lanes, the single-port data memory and the
// writeback stage.
interface dmem_lane_arbiter_if #(
    parameter int ADDR_W = 32
);
  // Handshake: reqN_valid qualifies lane N's request. stall is the inverse of
  // ready for both lanes together: while stall is high the requester must hold
  // both lanes' requests unchanged into the next cycle. There is no ready on
  // the response side; respN_valid is a one-cycle pulse.
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [31:0]       req0_wdata;
  logic [5:0]        req0_alucode;
  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [31:0]       req1_wdata;
  logic [5:0]        req1_alucode;

  logic              stall;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  logic              resp0_valid;
  logic [5:0]        resp0_alucode;
  logic [4:0]        resp0_byte_offset;
  logic              resp0_is_hardware;
  logic              resp1_valid;
  logic [5:0]        resp1_alucode;
  logic [4:0]        resp1_byte_offset;
  logic              resp1_is_hardware;
  logic              misalign;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_alucode,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_alucode,
    input  stall, mem_en, mem_we, mem_addr, mem_wdata,
    input  resp0_valid, resp0_alucode, resp0_byte_offset, resp0_is_hardware,
    input  resp1_valid, resp1_alucode, resp1_byte_offset, resp1_is_hardware,
    input  misalign
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_alucode,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_alucode,
    output stall, mem_en, mem_we, mem_addr, mem_wdata,
    output resp0_valid, resp0_alucode, resp0_byte_offset, resp0_is_hardware,
    output resp1_valid, resp1_alucode, resp1_byte_offset, resp1_is_hardware,
    output misalign
  );
endinterface

// File: rtl/dmem_lane_arbiter_store_align.sv
// Combinational byte-lane alignment: byte strobes, shifted store data and
// misalignment detection for one memory op.
module dmem_store_align
  import dmem_lane_arbiter_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] data,
  output logic        misalign
);

  always_comb begin
    we       = 4'b0000;
    misalign = 1'b0;
    data     = wdata << {addr_lo, 3'b000};
    case (alu_size(alucode))
      SZ_BYTE: we = 4'b0001 << addr_lo;
      SZ_HALF: begin
        misalign = addr_lo[0];
        we       = 4'b0011 << addr_lo;
      end
      SZ_WORD: begin
        misalign = |addr_lo;
        we       = 4'b1111 << addr_lo;
      end
      default: we = 4'b0000;
    endcase
    if (misalign) we = 4'b0000;
  end

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Shares the single-port data memory between two issue lanes, serialising
// same-cycle ops in program order and registering load metadata for writeback.
module dmem_lane_arbiter
  import dmem_lane_arbiter_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] HC_ADDR = ADDR_W'(HARDWARE_COUNTER_ADDR)
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_lane_arbiter_if.slave   bus,
  output arb_state_t           dbg_state
);

  arb_state_t        state_q, state_d;
  logic              v0, v1;
  logic              sel_valid, sel_lane, stall_c;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [5:0]        sel_alucode;
  logic [3:0]        align_we;
  logic [31:0]       align_data;
  logic              align_mis;
  logic              is_hc, issue_ok, mem_en_c, load_issue;

  logic              r0_valid, r1_valid, r0_hw, r1_hw, mis_q;
  logic [5:0]        r0_code, r1_code;
  logic [4:0]        r0_off, r1_off;

  assign v0 = bus.req0_valid && (alu_size(bus.req0_alucode) != SZ_NONE);
  assign v1 = bus.req1_valid && (alu_size(bus.req1_alucode) != SZ_NONE);

  // Lane0 is older, so it goes first; lane1 follows in SECOND using the
  // requests the pipeline holds stable because of stall.
  always_comb begin
    state_d   = state_q;
    sel_valid = 1'b0;
    sel_lane  = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (v0) begin
          sel_valid = 1'b1;
          if (v1) begin
            stall_c = 1'b1;
            state_d = ST_SECOND;
          end
        end else if (v1) begin
          sel_valid = 1'b1;
          sel_lane  = 1'b1;
        end
      end
      ST_SECOND: begin
        sel_valid = v1;
        sel_lane  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      sel_valid = 1'b0;
      stall_c   = 1'b0;
    end
  end

  always_comb begin
    if (sel_lane) begin
      sel_we      = bus.req1_we;
      sel_addr    = bus.req1_addr;
      sel_wdata   = bus.req1_wdata;
      sel_alucode = bus.req1_alucode;
    end else begin
      sel_we      = bus.req0_we;
      sel_addr    = bus.req0_addr;
      sel_wdata   = bus.req0_wdata;
      sel_alucode = bus.req0_alucode;
    end
  end

  dmem_store_align u_align (
    .alucode  (sel_alucode),
    .addr_lo  (sel_addr[1:0]),
    .wdata    (sel_wdata),
    .we       (align_we),
    .data     (align_data),
    .misalign (align_mis)
  );

  // The hardware counter lives outside memory: loads still respond, stores vanish.
  assign is_hc      = (sel_addr == HC_ADDR);
  assign issue_ok   = sel_valid && !align_mis;
  assign mem_en_c   = issue_ok && !is_hc;
  assign load_issue = issue_ok && !sel_we;

  assign bus.stall     = stall_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = (mem_en_c && sel_we) ? align_we : 4'b0000;
  assign bus.mem_addr  = sel_valid ? {sel_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata = (sel_valid && sel_we) ? align_data : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r0_code  <= 6'h0;
      r1_code  <= 6'h0;
      r0_off   <= 5'h0;
      r1_off   <= 5'h0;
      r0_hw    <= 1'b0;
      r1_hw    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r0_valid <= load_issue && !sel_lane;
      r1_valid <= load_issue && sel_lane;
      mis_q    <= sel_valid && align_mis;
      if (load_issue && !sel_lane) begin
        r0_code <= sel_alucode;
        r0_off  <= {sel_addr[1:0], 3'b000};
        r0_hw   <= is_hc;
      end
      if (load_issue && sel_lane) begin
        r1_code <= sel_alucode;
        r1_off  <= {sel_addr[1:0], 3'b000};
        r1_hw   <= is_hc;
      end
    end
  end

  assign bus.resp0_valid       = r0_valid;
  assign bus.resp0_alucode     = r0_code;
  assign bus.resp0_byte_offset = r0_off;
  assign bus.resp0_is_hardware = r0_hw;
  assign bus.resp1_valid       = r1_valid;
  assign bus.resp1_alucode     = r1_code;
  assign bus.resp1_byte_offset = r1_off;
  assign bus.resp1_is_hardware = r1_hw;
  assign bus.misalign          = mis_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Bench for dmem_lane_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a backlog-queue model of the arbiter.
module tb_dmem_lane_arbiter;
  import dmem_lane_arbiter_pkg::*;

  localparam logic [31:0] HC = 32'hffffff00;
  localparam int W = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_lane_arbiter_if #(.ADDR_W(32)) bus ();
  arb_state_t dbg_state;

  dmem_lane_arbiter #(.ADDR_W(32), .HC_ADDR(HC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic stall_prev = 1'b0;
  logic [5:0] codes [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_bytes(input logic [5:0] c);
    if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
    if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
    if (c == ALU_LW || c == ALU_SW) return 4;
    return 0;
  endfunction

  function automatic logic is_store_code(input logic [5:0] c);
    return (c == ALU_SB || c == ALU_SH || c == ALU_SW);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_lane(input int lane, input logic v, input logic [5:0] code,
                          input logic [31:0] addr, input logic [31:0] data);
    if (lane == 0) begin
      bus.req0_valid = v; bus.req0_we = is_store_code(code); bus.req0_addr = addr;
      bus.req0_wdata = data; bus.req0_alucode = code;
    end else begin
      bus.req1_valid = v; bus.req1_we = is_store_code(code); bus.req1_addr = addr;
      bus.req1_wdata = data; bus.req1_alucode = code;
    end
  endtask

  task automatic idle_lanes();
    set_lane(0, 1'b0, ALU_LW, 32'h0, 32'h0);
    set_lane(1, 1'b0, ALU_LW, 32'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lane(input int lane);
    logic [5:0] code;
    logic [31:0] addr;
    int k;
    k = $urandom_range(0, 8);
    code = (k == 8) ? 6'h3f : codes[k];
    case ($urandom_range(0, 7))
      0: addr = HC;
      1: addr = HC + 32'($urandom_range(1, 3));
      default: addr = 32'h100 + 32'($urandom_range(0, 63));
    endcase
    set_lane(lane, ($urandom_range(0, 9) < 7), code, addr, $urandom());
  endtask

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int pend_q[$];
  logic        lv_ok [2];
  logic        lw [2];
  logic [31:0] la [2];
  logic [31:0] ld [2];
  logic [5:0]  lc [2];
  logic        rv [2];
  logic [5:0]  rc [2];
  logic [4:0]  ro [2];
  logic        rh [2];
  logic        pv0, ph0, pv1, ph1, pmis, nmis, e_stall, e_en, hc;
  logic [5:0]  pc0, pc1;
  logic [4:0]  po0, po1;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata, a;
  logic [W-1:0] pkt;
  int issue, lane, bytes, off;

  initial begin
    exp_q.push_back('0);
    forever begin
      @(negedge clk);
      pkt = exp_q.pop_front();
      {pv0, pc0, po0, ph0, pv1, pc1, po1, ph1, pmis} = pkt;
      check("resp0_valid", 32'(bus.resp0_valid), 32'(pv0));
      check("resp1_valid", 32'(bus.resp1_valid), 32'(pv1));
      check("misalign", 32'(bus.misalign), 32'(pmis));
      if (pv0) begin
        check("resp0_alucode", 32'(bus.resp0_alucode), 32'(pc0));
        check("resp0_byte_offset", 32'(bus.resp0_byte_offset), 32'(po0));
        check("resp0_is_hardware", 32'(bus.resp0_is_hardware), 32'(ph0));
      end
      if (pv1) begin
        check("resp1_alucode", 32'(bus.resp1_alucode), 32'(pc1));
        check("resp1_byte_offset", 32'(bus.resp1_byte_offset), 32'(po1));
        check("resp1_is_hardware", 32'(bus.resp1_is_hardware), 32'(ph1));
      end

      lv_ok[0] = bus.req0_valid && (code_bytes(bus.req0_alucode) != 0);
      lv_ok[1] = bus.req1_valid && (code_bytes(bus.req1_alucode) != 0);
      lw[0] = bus.req0_we;   lw[1] = bus.req1_we;
      la[0] = bus.req0_addr; la[1] = bus.req1_addr;
      ld[0] = bus.req0_wdata; ld[1] = bus.req1_wdata;
      lc[0] = bus.req0_alucode; lc[1] = bus.req1_alucode;

      issue = -1; e_stall = 0; e_en = 0; e_we = 4'h0; e_addr = 0; e_wdata = 0; nmis = 0;
      for (int i = 0; i < 2; i++) begin
        rv[i] = 0; rc[i] = 0; ro[i] = 0; rh[i] = 0;
      end
      // Ops waiting behind an older op in the same cycle go out one per cycle.
      if (rst) pend_q.delete();
      else if (pend_q.size() > 0) begin
        lane = pend_q.pop_front();
        issue = lv_ok[lane] ? lane : -1;
      end else begin
        if (lv_ok[0]) issue = 0;
        else if (lv_ok[1]) issue = 1;
        if (lv_ok[0] && lv_ok[1]) begin
          pend_q.push_back(1);
          e_stall = 1;
        end
      end

      if (issue >= 0) begin
        a = la[issue];
        bytes = code_bytes(lc[issue]);
        off = int'(a % 4);
        hc = (a == HC);
        e_addr = a & ~32'h3;
        if (lw[issue]) e_wdata = ld[issue] << (8 * off);
        if ((a % bytes) != 0) nmis = 1;
        else if (lw[issue]) begin
          if (!hc) begin
            e_en = 1;
            e_we = 4'(((32'd1 << bytes) - 32'd1) << off);
          end
        end else begin
          e_en = !hc;
          rv[issue] = 1; rc[issue] = lc[issue]; ro[issue] = 5'(off * 8); rh[issue] = hc;
        end
      end

      check("stall", 32'(bus.stall), 32'(e_stall));
      check("mem_en", 32'(bus.mem_en), 32'(e_en));
      check("mem_we", 32'(bus.mem_we), 32'(e_we));
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wdata", bus.mem_wdata, e_wdata);
      exp_q.push_back({rv[0], rc[0], ro[0], rh[0], rv[1], rc[1], ro[1], rh[1], nmis});
      stall_prev = bus.stall;
    end
  end

  // ---------------- stimulus + literal expectations ----------------
  initial begin
    idle_lanes();
    rst = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
    check("rst_resp0_alucode", 32'(bus.resp0_alucode), 32'd0);
    check("rst_misalign", 32'(bus.misalign), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // single load
    next_cycle(); rst = 1'b0; set_lane(0, 1'b1, ALU_LW, 32'h100, 32'h0);
    @(negedge clk);
    check("ld_mem_en", 32'(bus.mem_en), 32'd1);
    check("ld_mem_addr", bus.mem_addr, 32'h100);
    check("ld_mem_we", 32'(bus.mem_we), 32'd0);
    check("ld_stall", 32'(bus.stall), 32'd0);
    next_cycle(); idle_lanes();
    @(negedge clk);
    check("ld_resp0_valid", 32'(bus.resp0_valid), 32'd1);
    check("ld_resp0_off", 32'(bus.resp0_byte_offset), 32'd0);
    check("ld_resp1_valid", 32'(bus.resp1_valid), 32'd0);

    // dual op: store then byte load
    next_cycle();
    set_lane(0, 1'b1, ALU_SW, 32'h200, 32'hdeadbeef);
    set_lane(1, 1'b1, ALU_LBU, 32'h203, 32'h0);
    @(negedge clk);
    check("dual_stall0", 32'(bus.stall), 32'd1);
    check("dual_we0", 32'(bus.mem_we), 32'hf);
    check("dual_wdata0", bus.mem_wdata, 32'hdeadbeef);
    next_cycle();
    @(negedge clk);
    check("dual_addr1", bus.mem_addr, 32'h200);
    check("dual_we1", 32'(bus.mem_we), 32'd0);
    check("dual_stall1", 32'(bus.stall), 32'd0);
    check("dual_en1", 32'(bus.mem_en), 32'd1);
    next_cycle(); idle_lanes();
    @(negedge clk);
    check("dual_resp1_valid", 32'(bus.resp1_valid), 32'd1);
    check("dual_resp1_off", 32'(bus.resp1_byte_offset), 32'd24);
    check("dual_resp0_valid", 32'(bus.resp0_valid), 32'd0);

    // sub-word store on lane1
    next_cycle(); set_lane(1, 1'b1, ALU_SH, 32'h12, 32'h0000abcd);
    @(negedge clk);
    check("sh_we", 32'(bus.mem_we), 32'hc);
    check("sh_wdata", bus.mem_wdata, 32'habcd0000);
    check("sh_addr", bus.mem_addr, 32'h10);

    // hardware counter load then store
    next_cycle(); idle_lanes(); set_lane(0, 1'b1, ALU_LW, HC, 32'h0);
    @(negedge clk);
    check("hc_ld_en", 32'(bus.mem_en), 32'd0);
    next_cycle(); set_lane(0, 1'b1, ALU_SW, HC, 32'h12345678);
    @(negedge clk);
    check("hc_ld_resp0_valid", 32'(bus.resp0_valid), 32'd1);
    check("hc_ld_is_hw", 32'(bus.resp0_is_hardware), 32'd1);
    check("hc_st_en", 32'(bus.mem_en), 32'd0);
    check("hc_st_we", 32'(bus.mem_we), 32'd0);
    next_cycle(); idle_lanes();
    @(negedge clk);
    check("hc_st_resp0_valid", 32'(bus.resp0_valid), 32'd0);
    check("hc_st_misalign", 32'(bus.misalign), 32'd0);

    // misaligned word load
    next_cycle(); set_lane(0, 1'b1, ALU_LW, 32'h102, 32'h0);
    @(negedge clk);
    check("mis_en", 32'(bus.mem_en), 32'd0);
    next_cycle(); idle_lanes();
    @(negedge clk);
    check("mis_pulse", 32'(bus.misalign), 32'd1);
    check("mis_resp0_valid", 32'(bus.resp0_valid), 32'd0);

    // reset while lane1 is waiting
    next_cycle();
    set_lane(0, 1'b1, ALU_LW, 32'h300, 32'h0);
    set_lane(1, 1'b1, ALU_LW, 32'h304, 32'h0);
    @(negedge clk);
    check("rmo_stall", 32'(bus.stall), 32'd1);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; idle_lanes();
    @(negedge clk);
    check("rmo_stall_after", 32'(bus.stall), 32'd0);
    check("rmo_en_after", 32'(bus.mem_en), 32'd0);
    check("rmo_resp0_valid", 32'(bus.resp0_valid), 32'd0);
    check("rmo_resp1_valid", 32'(bus.resp1_valid), 32'd0);
    check("rmo_state", 32'(dbg_state), 32'(ST_IDLE));
    next_cycle(); set_lane(0, 1'b1, ALU_LW, 32'h100, 32'h0);
    @(negedge clk);
    check("rmo_single_stall", 32'(bus.stall), 32'd0);
    check("rmo_single_en", 32'(bus.mem_en), 32'd1);

    // randomized traffic; requests are held whenever the arbiter stalls
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst = ($urandom_range(0, 99) == 0);
      if (!stall_prev) begin
        rand_lane(0);
        rand_lane(1);
      end
    end

    next_cycle(); rst = 1'b0; idle_lanes();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
